// File: rtl/regbank_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : regbank_wr_sched
// Purpose  : Write-port scheduler and hazard scoreboard for the 16 x 32-bit
//            register bank. Merges load-return data and ALU results onto the
//            single bank write port, buffers ALU writes that lose arbitration,
//            tracks outstanding loads and flags read/write hazards at issue.
// Ports    : clk, rst_n (async, active-low)
//            alu_wr_en/dest/data, alu_wr_ready  - ALU write request channel
//            ld_issue, ld_issue_dest            - load issued (sets pending)
//            ldr_wr_en/dest/data                - load data return
//            chk_valid, src_1_sel, src_2_sel,
//            chk_dest, stall                    - hazard check at issue
//            wr_en, wr_dest, wr_data            - registered bank write port
//            pend_mask                          - registers awaiting a load
// Options  : REG0_ZERO_EN - register 0 hardwired to zero (writes to r0 are
//            consumed silently, r0 never pending, never hazards).
// Revision : 1.0 - initial release
// ============================================================================
module regbank_wr_sched #(
  parameter int NREG      = 16,
  parameter int AW        = 4,
  parameter int DW        = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_wr_en,
  input  logic [AW-1:0]   alu_wr_dest,
  input  logic [DW-1:0]   alu_wr_data,
  output logic            alu_wr_ready,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_dest,
  input  logic            ldr_wr_en,
  input  logic [AW-1:0]   ldr_wr_dest,
  input  logic [DW-1:0]   ldr_wr_data,
  input  logic            chk_valid,
  input  logic [AW-1:0]   src_1_sel,
  input  logic [AW-1:0]   src_2_sel,
  input  logic [AW-1:0]   chk_dest,
  output logic            stall,
  output logic            wr_en,
  output logic [AW-1:0]   wr_dest,
  output logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] pend_mask
);

  localparam int c_PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_CW = $clog2(BUF_DEPTH + 1);

`ifdef REG0_ZERO_EN
  localparam logic c_R0_ZERO = 1'b1;
`else
  localparam logic c_R0_ZERO = 1'b0;
`endif

  localparam logic [NREG-1:0] c_ONE     = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREG-1:0] c_R0_MASK = {{(NREG-1){1'b0}}, c_R0_ZERO};

  // ALU write buffer storage; a per-slot valid bit makes the hazard search
  // independent of pointer arithmetic.
  logic [AW-1:0]        r_buf_dest [BUF_DEPTH];
  logic [DW-1:0]        r_buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_buf_vld;
  logic [c_PW-1:0]      r_wr_ptr;
  logic [c_PW-1:0]      r_rd_ptr;
  logic [c_CW-1:0]      r_count;

  logic                 r_wr_en;
  logic [AW-1:0]        r_wr_dest;
  logic [DW-1:0]        r_wr_data;
  logic [NREG-1:0]      r_pend_mask;

  logic                 w_alu_ready;
  logic                 w_alu_live;
  logic                 w_ldr_live;
  logic                 w_buf_empty;
  logic                 w_sel_head;
  logic                 w_sel_byp;
  logic                 w_push;
  logic                 w_pop;
  logic [NREG-1:0]      w_hit_vec;
  logic [NREG-1:0]      w_set;
  logic [NREG-1:0]      w_clr;

  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    if (p == c_PW'(BUF_DEPTH - 1)) f_next = '0;
    else                           f_next = p + 1'b1;
  endfunction

  assign w_alu_ready  = (r_count < c_CW'(BUF_DEPTH));
  assign alu_wr_ready = w_alu_ready;
  assign w_buf_empty  = (r_count == '0);

  // "live" writes are the ones that actually reach the bank; a write to a
  // hardwired-zero r0 is accepted but goes nowhere.
  assign w_alu_live = alu_wr_en && w_alu_ready && !(c_R0_ZERO && (alu_wr_dest == '0));
  assign w_ldr_live = ldr_wr_en && !(c_R0_ZERO && (ldr_wr_dest == '0));

  // Port priority: load return, then buffer head, then direct ALU bypass.
  assign w_sel_head = !w_ldr_live && !w_buf_empty;
  assign w_sel_byp  = !w_ldr_live && w_buf_empty && w_alu_live;
  assign w_push     = w_alu_live && !w_sel_byp;
  assign w_pop      = w_sel_head;

  // Per-register "write not yet landed" vector.
  always_comb begin
    w_hit_vec = r_pend_mask;
    if (r_wr_en)   w_hit_vec[r_wr_dest]   = 1'b1;
    if (ldr_wr_en) w_hit_vec[ldr_wr_dest] = 1'b1;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (r_buf_vld[i]) w_hit_vec[r_buf_dest[i]] = 1'b1;
    end
    w_hit_vec = w_hit_vec & ~c_R0_MASK;
  end

  assign stall = chk_valid &&
                 (w_hit_vec[src_1_sel] || w_hit_vec[src_2_sel] || w_hit_vec[chk_dest]);

  // An issue while stalled is not honoured; set is applied after clear so a
  // simultaneous new load to the same register stays pending.
  assign w_set = (ld_issue && !stall) ? ((c_ONE << ld_issue_dest) & ~c_R0_MASK) : '0;
  assign w_clr = ldr_wr_en ? (c_ONE << ldr_wr_dest) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_dest[i] <= '0;
        r_buf_data[i] <= '0;
      end
      r_buf_vld   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_dest   <= '0;
      r_wr_data   <= '0;
      r_pend_mask <= '0;
    end else begin
      // Push and pop never target the same slot: a pop needs a non-empty
      // buffer, a push needs a non-full one, so the pointers differ.
      if (w_pop) begin
        r_buf_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr            <= f_next(r_rd_ptr);
      end
      if (w_push) begin
        r_buf_dest[r_wr_ptr] <= alu_wr_dest;
        r_buf_data[r_wr_ptr] <= alu_wr_data;
        r_buf_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr             <= f_next(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_ldr_live) begin
        r_wr_en   <= 1'b1;
        r_wr_dest <= ldr_wr_dest;
        r_wr_data <= ldr_wr_data;
      end else if (w_sel_head) begin
        r_wr_en   <= 1'b1;
        r_wr_dest <= r_buf_dest[r_rd_ptr];
        r_wr_data <= r_buf_data[r_rd_ptr];
      end else if (w_sel_byp) begin
        r_wr_en   <= 1'b1;
        r_wr_dest <= alu_wr_dest;
        r_wr_data <= alu_wr_data;
      end else begin
        r_wr_en   <= 1'b0;
      end

      r_pend_mask <= (r_pend_mask & ~w_clr) | w_set;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_dest   = r_wr_dest;
  assign wr_data   = r_wr_data;
  assign pend_mask = r_pend_mask;

endmodule
`default_nettype wire

// File: tb/tb_regbank_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_wr_sched
// Purpose  : Self-checking bench for regbank_wr_sched: directed vector table,
//            hand sequences for reset and r0 handling, then random traffic
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_wr_sched;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int BD   = 2;

`ifdef REG0_ZERO_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif

  typedef struct {
    logic          alu_en;
    logic [AW-1:0] alu_dest;
    logic [DW-1:0] alu_data;
    logic          ldr_en;
    logic [AW-1:0] ldr_dest;
    logic [DW-1:0] ldr_data;
    logic          ld_iss;
    logic [AW-1:0] ld_dest;
    logic          chk;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] cd;
  } in_t;

  typedef struct {
    in_t             v;
    logic            ready;
    logic            stall;
    logic            wr_en;
    logic [AW-1:0]   dest;
    logic [DW-1:0]   data;
    logic [NREG-1:0] pend;
  } row_t;

  logic            clk, rst_n;
  logic            alu_wr_en, alu_wr_ready, ld_issue, ldr_wr_en, chk_valid, stall, wr_en;
  logic [AW-1:0]   alu_wr_dest, ld_issue_dest, ldr_wr_dest, src_1_sel, src_2_sel, chk_dest, wr_dest;
  logic [DW-1:0]   alu_wr_data, ldr_wr_data, wr_data;
  logic [NREG-1:0] pend_mask;

  int n_cmp = 0;
  int n_err = 0;

  regbank_wr_sched #(.NREG(NREG), .AW(AW), .DW(DW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wr_en(alu_wr_en), .alu_wr_dest(alu_wr_dest), .alu_wr_data(alu_wr_data),
    .alu_wr_ready(alu_wr_ready),
    .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest),
    .ldr_wr_en(ldr_wr_en), .ldr_wr_dest(ldr_wr_dest), .ldr_wr_data(ldr_wr_data),
    .chk_valid(chk_valid), .src_1_sel(src_1_sel), .src_2_sel(src_2_sel),
    .chk_dest(chk_dest), .stall(stall),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data), .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [AW-1:0]   mq_dest[$];
  logic [DW-1:0]   mq_data[$];
  logic [NREG-1:0] m_pend;
  logic            m_wr_en;
  logic [AW-1:0]   m_wr_dest;
  logic [DW-1:0]   m_wr_data;
  logic            m_ready, m_stall;

  task automatic model_reset();
    mq_dest.delete(); mq_data.delete();
    m_pend = '0; m_wr_en = 1'b0; m_wr_dest = '0; m_wr_data = '0;
  endtask

  function automatic bit m_busy(logic [AW-1:0] r, in_t v);
    if (Z && r == 0) return 1'b0;
    if (m_pend[r]) return 1'b1;
    foreach (mq_dest[i]) if (mq_dest[i] == r) return 1'b1;
    if (m_wr_en && m_wr_dest == r) return 1'b1;
    if (v.ldr_en && v.ldr_dest == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(in_t v);
    bit alu_real, ld_real, honour;
    alu_real = v.alu_en && m_ready && !(Z && v.alu_dest == 0);
    ld_real  = v.ldr_en && !(Z && v.ldr_dest == 0);
    honour   = v.ld_iss && !m_stall;
    if (ld_real) begin
      m_wr_en = 1'b1; m_wr_dest = v.ldr_dest; m_wr_data = v.ldr_data;
    end else if (mq_dest.size() > 0) begin
      m_wr_en = 1'b1; m_wr_dest = mq_dest.pop_front(); m_wr_data = mq_data.pop_front();
    end else if (alu_real) begin
      m_wr_en = 1'b1; m_wr_dest = v.alu_dest; m_wr_data = v.alu_data;
      alu_real = 1'b0;
    end else begin
      m_wr_en = 1'b0;
    end
    if (alu_real) begin
      mq_dest.push_back(v.alu_dest); mq_data.push_back(v.alu_data);
    end
    if (v.ldr_en) m_pend[v.ldr_dest] = 1'b0;
    if (honour && !(Z && v.ld_dest == 0)) m_pend[v.ld_dest] = 1'b1;
  endtask

  // ---------------- helpers ----------------
  function automatic in_t mk(logic ae, logic [AW-1:0] ad, logic [DW-1:0] adt,
                             logic le, logic [AW-1:0] ld, logic [DW-1:0] ldt,
                             logic li, logic [AW-1:0] lid,
                             logic c, logic [AW-1:0] s1, logic [AW-1:0] s2, logic [AW-1:0] cd);
    in_t v;
    v.alu_en = ae; v.alu_dest = ad; v.alu_data = adt;
    v.ldr_en = le; v.ldr_dest = ld; v.ldr_data = ldt;
    v.ld_iss = li; v.ld_dest = lid;
    v.chk = c; v.s1 = s1; v.s2 = s2; v.cd = cd;
    return v;
  endfunction

  task automatic drive(in_t v);
    alu_wr_en = v.alu_en; alu_wr_dest = v.alu_dest; alu_wr_data = v.alu_data;
    ldr_wr_en = v.ldr_en; ldr_wr_dest = v.ldr_dest; ldr_wr_data = v.ldr_data;
    ld_issue = v.ld_iss;  ld_issue_dest = v.ld_dest;
    chk_valid = v.chk; src_1_sel = v.s1; src_2_sel = v.s2; chk_dest = v.cd;
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1: drive, sample combinational outputs at the
  // falling edge, clock, sample registered outputs 1 unit after the edge.
  task automatic run_cycle(input in_t v, output logic rdy, output logic st,
                           output logic we, output logic [AW-1:0] d,
                           output logic [DW-1:0] dt, output logic [NREG-1:0] pm);
    drive(v);
    #4;
    rdy = alu_wr_ready;
    st  = stall;
    m_ready = (mq_dest.size() < BD);
    m_stall = v.chk && (m_busy(v.s1, v) || m_busy(v.s2, v) || m_busy(v.cd, v));
    @(posedge clk);
    model_update(v);
    #1;
    we = wr_en; d = wr_dest; dt = wr_data; pm = pend_mask;
  endtask

  row_t tbl[$];

  task automatic add(in_t v, logic r, logic s, logic we, logic [AW-1:0] d,
                     logic [DW-1:0] dt, logic [NREG-1:0] pm);
    row_t x;
    x.v = v; x.ready = r; x.stall = s; x.wr_en = we; x.dest = d; x.data = dt; x.pend = pm;
    tbl.push_back(x);
  endtask

  function automatic in_t ck(logic [AW-1:0] s1, logic [AW-1:0] s2, logic [AW-1:0] cd);
    return mk(0,0,0, 0,0,0, 0,0, 1,s1,s2,cd);
  endfunction

  initial begin
    logic            rdy, st, we;
    logic [AW-1:0]   d;
    logic [DW-1:0]   dt;
    logic [NREG-1:0] pm;
    in_t             idle, v;

    idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0,0);
    // ALU bypass, load collision, buffer full, load hazard, set/clear race.
    add(ck(0,0,0),                                  1,0, 0,0,32'h0,0);
    add(mk(1,3,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0,0),  1,0, 1,3,32'hDEADBEEF,0);
    add(ck(3,0,0),                                  1,1, 0,3,32'hDEADBEEF,0);
    add(mk(1,6,32'h22, 1,5,32'h11, 0,0, 1,6,0,0),   1,0, 1,5,32'h11,0);
    add(ck(6,0,0),                                  1,1, 1,6,32'h22,0);
    add(ck(6,0,0),                                  1,1, 0,6,32'h22,0);
    add(mk(1,2,32'hB2, 1,1,32'hA1, 0,0, 0,0,0,0),   1,0, 1,1,32'hA1,0);
    add(mk(1,2,32'hB3, 1,1,32'hA2, 0,0, 0,0,0,0),   1,0, 1,1,32'hA2,0);
    add(mk(1,4,32'hB4, 1,1,32'hA3, 0,0, 0,0,0,0),   0,0, 1,1,32'hA3,0);
    add(mk(1,4,32'hB4, 0,0,0, 0,0, 0,0,0,0),        0,0, 1,2,32'hB2,0);
    add(mk(1,4,32'hB4, 0,0,0, 0,0, 0,0,0,0),        1,0, 1,2,32'hB3,0);
    add(idle,                                       1,0, 1,4,32'hB4,0);
    add(ck(4,0,0),                                  1,1, 0,4,32'hB4,0);
    add(mk(0,0,0, 0,0,0, 1,7, 0,0,0,0),             1,0, 0,4,32'hB4,16'h0080);
    add(ck(7,0,0),                                  1,1, 0,4,32'hB4,16'h0080);
    add(ck(1,7,0),                                  1,1, 0,4,32'hB4,16'h0080);
    add(mk(0,0,0, 1,7,32'h77, 0,0, 1,1,1,7),        1,1, 1,7,32'h77,0);
    add(ck(7,0,0),                                  1,1, 0,7,32'h77,0);
    add(ck(7,0,0),                                  1,0, 0,7,32'h77,0);
    add(mk(0,0,0, 0,0,0, 1,9, 0,0,0,0),             1,0, 0,7,32'h77,16'h0200);
    add(mk(0,0,0, 1,9,32'h99, 1,9, 0,0,0,0),        1,0, 1,9,32'h99,16'h0200);
    add(mk(0,0,0, 1,9,32'h9A, 0,0, 1,2,8,9),        1,1, 1,9,32'h9A,0);
    add(mk(0,0,0, 1,12,32'hC, 0,0, 0,0,0,0),        1,0, 1,12,32'hC,0);
    add(mk(0,0,0, 0,0,0, 1,15, 1,12,0,0),           1,1, 0,12,32'hC,0);

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(idle);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset wr_en", wr_en, 0);
    cmp("reset wr_dest", wr_dest, 0);
    cmp("reset wr_data", wr_data, 0);
    cmp("reset pend_mask", pend_mask, 0);
    cmp("reset alu_wr_ready", alu_wr_ready, 1);
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    foreach (tbl[i]) begin
      run_cycle(tbl[i].v, rdy, st, we, d, dt, pm);
      cmp($sformatf("tbl%0d ready", i), rdy, tbl[i].ready);
      cmp($sformatf("tbl%0d stall", i), st, tbl[i].stall);
      cmp($sformatf("tbl%0d wr_en", i), we, tbl[i].wr_en);
      cmp($sformatf("tbl%0d wr_dest", i), d, tbl[i].dest);
      cmp($sformatf("tbl%0d wr_data", i), dt, tbl[i].data);
      cmp($sformatf("tbl%0d pend", i), pm, tbl[i].pend);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    run_cycle(mk(1,2,32'h1002, 1,1,32'h1001, 1,4, 0,0,0,0), rdy, st, we, d, dt, pm);
    run_cycle(mk(1,3,32'h1003, 1,1,32'h1004, 0,0, 0,0,0,0), rdy, st, we, d, dt, pm);
    drive(idle);
    cmp("pre-reset ready", alu_wr_ready, 0);
    cmp("pre-reset pend", pend_mask, 16'h0010);
    #1 rst_n = 1'b0;
    #1;
    cmp("midrst wr_en", wr_en, 0);
    cmp("midrst pend", pend_mask, 0);
    cmp("midrst ready", alu_wr_ready, 1);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(idle, rdy, st, we, d, dt, pm);
      cmp($sformatf("postrst%0d wr_en", i), we, 0);
      cmp($sformatf("postrst%0d ready", i), rdy, 1);
    end

    // ---------------- register 0 handling ----------------
    run_cycle(mk(1,0,32'h55, 0,0,0, 0,0, 0,0,0,0), rdy, st, we, d, dt, pm);
    cmp("r0 alu wr_en", we, {31'b0, !Z});
    run_cycle(ck(0,0,0), rdy, st, we, d, dt, pm);
    cmp("r0 stall", st, {31'b0, !Z});
    run_cycle(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0), rdy, st, we, d, dt, pm);
    cmp("r0 pend", pm[0], {31'b0, !Z});

    // ---------------- random traffic vs model ----------------
    for (int n = 0; n < 400; n++) begin
      v = mk($urandom_range(0,1), AW'($urandom_range(0,7)), $urandom,
             ($urandom_range(0,9) < 3), AW'($urandom_range(0,7)), $urandom,
             ($urandom_range(0,9) < 3), AW'($urandom_range(0,7)),
             $urandom_range(0,1), AW'($urandom_range(0,7)),
             AW'($urandom_range(0,7)), AW'($urandom_range(0,7)));
      run_cycle(v, rdy, st, we, d, dt, pm);
      cmp($sformatf("rnd%0d ready", n), rdy, m_ready);
      cmp($sformatf("rnd%0d stall", n), st, m_stall);
      cmp($sformatf("rnd%0d wr_en", n), we, m_wr_en);
      cmp($sformatf("rnd%0d wr_dest", n), d, m_wr_dest);
      cmp($sformatf("rnd%0d wr_data", n), dt, m_wr_data);
      cmp($sformatf("rnd%0d pend", n), pm, m_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
